bcd_count_scan: RTL and testbench
=================================

// Module: bcd_count_scan
// PURPOSE
//   Multi-digit decimal counter with a time-multiplexed display scanner. It sits
//   directly upstream of the combinational BCD-to-7-segment decoder. bcd_out drives
//   the decoder's 4-bit digit input, and digit_sel drives the common anodes, so one
//   decoder serves all DIGITS displays.
// PARAMETERS
//   DIGITS        4     number of BCD digits, digit 0 = least significant (DIGITS>=2)
//   SCAN_DIV      1000  clk cycles each digit is shown before the scan advances (>=2)
//   BLANK_LEADING 1     1 = suppress leading zeros; digit 0 is never blanked
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   clear      in   1          synchronous clear of count to all zeros
//   load       in   1          synchronous load of load_val
//   load_val   in   4*DIGITS   BCD value to load, digit i at [4i+3:4i]
//   en         in   1          count enable, one step per cycle while high
//   up         in   1          1 = increment, 0 = decrement
//   count      out  4*DIGITS   current BCD count (registered)
//   carry      out  1          1-cycle pulse on wrap (all-9 to 0 up, 0 to all-9 down)
//   bcd_out    out  4          BCD digit currently scanned, to the decoder input
//   digit_sel  out  DIGITS     active-low one-hot anode select
//   blank      out  1          1 = current digit is a suppressed leading zero
// BEHAVIOUR
//   Reset (async, rst=1): count=0, carry=0, prescaler=0, scan index=0, bcd_out=0,
//     digit_sel = all ones except bit 0 low, blank=0. Outputs hold while rst is high.
//     Deasserting rst mid-scan restarts the scan at digit 0.
//   Count priority per cycle: clear > load > en. If none is active, count holds.
//   clear: count <= 0 next edge; carry=0.
//   load: each load_val nibble >9 is clamped to 9 as it is stored; carry=0.
//   en & up: ripple-BCD increment. A digit at 9 goes to 0 and carries into the next.
//     All digits at 9 -> all 0, with carry=1 on that same edge for exactly one cycle.
//   en & !up: ripple-BCD decrement. A digit at 0 goes to 9 and borrows from the next.
//     All digits at 0 -> all 9, with carry=1 for one cycle.
//   carry is registered and is 0 in every cycle without a wrap.
//   Latency: count reflects a clear, load or step 1 cycle after the sampling edge.
//   Scan prescaler: counts 0..SCAN_DIV-1 continuously and is unaffected by count
//     ops. On the edge where it equals SCAN_DIV-1 it returns to 0, and the scan
//     index advances idx -> (idx+1) mod DIGITS (DIGITS-1 wraps to 0).
//   bcd_out, digit_sel and blank are registered and update on the same edge as idx.
//     They always describe one digit coherently: bcd_out = count nibble idx,
//     digit_sel = ~(1<<idx).
//     Values are sampled from count as it stands at that edge. A count change while
//     a digit is showing appears at that digit's next scan slot.
//   Blanking (BLANK_LEADING=1): for idx>0, if nibbles idx..DIGITS-1 are all zero,
//     then blank=1, digit_sel=all ones (no anode on) and bcd_out=0.
//     With BLANK_LEADING=0, blank is tied to 0.
//   Simultaneous clear/load/en with a scan advance: the scanner samples the
//     pre-update count. There is no interaction beyond that.
// TESTING
//   1 Reset mid-operation: count=0x1234, assert rst asynchronously between edges
//     -> immediately count=0, digit_sel=4'b1110, bcd_out=0, carry=0.
//   2 Increment wrap: load 0x9998, en=1 up=1 for 2 cycles -> 0x9999 then 0x0000,
//     with carry=1 in the cycle count shows 0x0000 only.
//   3 Decrement wrap: load 0x0001, en=1 up=0 for 2 cycles -> 0x0000 then 0x9999,
//     carry pulses once. A further step gives 0x9998 with carry=0.
//   4 Priority and clamp: clear=1, load=1 (load_val=0x5555), en=1 -> count=0.
//     Next cycle load=1 only with load_val=0xA3F7 -> count=0x9397.
//   5 Scan (SCAN_DIV=4): count=0x0000 (BLANK_LEADING=1 throughout).
//     Shows digit_sel 1110 (blank=0), then 1111 with blank=1 for idx 1..3,
//     each held exactly 4 cycles, then back to 1110.
//   6 Scan values: count=0x0507 -> bcd_out sequence 7,0,5,0. The idx=1 zero is not
//     blanked (nibble 2 nonzero). The idx=3 zero is blanked with digit_sel=1111.
//     Repeats with period 16 cycles.

Source files
------------

// File: rtl/bcd_count_scan.sv
// Multi-digit BCD up/down counter with clear/load, plus a time-multiplexed
// display scanner that feeds one shared 7-segment decoder and active-low anodes.
module bcd_count_scan #(
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  blank
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [W-1:0]        inc_val;
    logic [W-1:0]        dec_val;
    logic [W-1:0]        clamp_val;
    logic                inc_wrap;
    logic                dec_wrap;
    logic [DIGITS-1:0]   zero_above;

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       nidx;
    logic                scan_tick;
    logic                nidx_blank;
    logic [3:0]          nidx_bcd;
    logic [3:0]          bcd_next;
    logic [DIGITS-1:0]   sel_next;

    // Ripple increment/decrement; the final carry/borrow out marks the wrap.
    always_comb begin : step_calc
        logic       c;
        logic       b;
        logic [3:0] d;
        inc_val = count;
        dec_val = count;
        c       = 1'b1;
        b       = 1'b1;
        d       = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (c) begin
                inc_val[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                c = (d == 4'd9);
            end
            if (b) begin
                dec_val[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                b = (d == 4'd0);
            end
        end
        inc_wrap = c;
        dec_wrap = b;
    end

    // zero_above[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin : zero_calc
        logic z;
        z          = 1'b1;
        zero_above = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z             = z & (count[4*i +: 4] == 4'd0);
            zero_above[i] = z;
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] lv;
            assign lv                   = load_val[4*gi +: 4];
            assign clamp_val[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;
            assign sel_next[gi]         = (nidx != IW'(gi)) | nidx_blank;
        end
    endgenerate

    assign scan_tick  = (presc == PW'(SCAN_DIV - 1));
    assign nidx       = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    assign nidx_bcd   = count[4*nidx +: 4];
    assign nidx_blank = (BLANK_LEADING != 0) && (nidx != '0) && zero_above[nidx];
    assign bcd_next   = nidx_blank ? 4'd0 : nidx_bcd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            carry     <= 1'b0;
            presc     <= '0;
            idx       <= '0;
            bcd_out   <= 4'd0;
            digit_sel <= {{(DIGITS-1){1'b1}}, 1'b0};
            blank     <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= clamp_val;
            end else if (en) begin
                if (up) begin
                    count <= inc_val;
                    carry <= inc_wrap;
                end else begin
                    count <= dec_val;
                    carry <= dec_wrap;
                end
            end

            // Scanner samples the pre-update count on the advance edge.
            if (scan_tick) begin
                presc     <= '0;
                idx       <= nidx;
                bcd_out   <= bcd_next;
                digit_sel <= sel_next;
                blank     <= nidx_blank;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_scan.sv
// Directed bench for bcd_count_scan: reset, wrap, priority/clamp, scan timing and blanking.
module tb_bcd_count_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        blank;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bcd_count_scan #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .BLANK_LEADING(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .load(load),
        .load_val(load_val),
        .en(en),
        .up(up),
        .count(count),
        .carry(carry),
        .bcd_out(bcd_out),
        .digit_sel(digit_sel),
        .blank(blank)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          id;
        logic [3:0]  bexp;
        logic [3:0]  sexp;
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
        step();
        step();
        check("rst_count", count, 16'h0000);
        check("rst_sel", digit_sel, 4'b1110);
        check("rst_bcd", bcd_out, 4'd0);
        check("rst_carry", carry, 1'b0);
        check("rst_blank", blank, 1'b0);
        rst = 1'b0;

        // Priority: clear beats load and en; then clamped load
        clear = 1'b1; load = 1'b1; load_val = 16'h5555; en = 1'b1;
        step();
        check("prio_clear", count, 16'h0000);
        check("prio_carry", carry, 1'b0);
        clear = 1'b0; en = 1'b0; load_val = 16'hA3F7;
        step();
        check("clamp_load", count, 16'h9397);

        // Increment wrap
        load_val = 16'h9998;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check("inc_9999", count, 16'h9999);
        check("inc_nocarry", carry, 1'b0);
        step();
        check("inc_wrap", count, 16'h0000);
        check("inc_carry", carry, 1'b1);
        en = 1'b0;
        step();
        check("inc_hold", count, 16'h0000);
        check("inc_carry_drop", carry, 1'b0);

        // Decrement wrap
        load = 1'b1; load_val = 16'h0001;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check("dec_0000", count, 16'h0000);
        check("dec_nocarry", carry, 1'b0);
        step();
        check("dec_wrap", count, 16'h9999);
        check("dec_carry", carry, 1'b1);
        step();
        check("dec_9998", count, 16'h9998);
        check("dec_carry_drop", carry, 1'b0);
        en = 1'b0;
        step();
        check("hold", count, 16'h9998);

        // Asynchronous reset between edges
        load = 1'b1; load_val = 16'h1234;
        step();
        load = 1'b0;
        check("pre_rst", count, 16'h1234);
        #2;
        rst = 1'b1;
        #1;
        check("async_count", count, 16'h0000);
        check("async_sel", digit_sel, 4'b1110);
        check("async_bcd", bcd_out, 4'd0);
        check("async_carry", carry, 1'b0);
        step();
        check("rst_held", count, 16'h0000);
        rst = 1'b0;
        cyc = 0;

        // Scan of all-zero count: digit 0 shown, upper digits blanked, 4 cycles each
        for (int k = 1; k <= 16; k++) begin
            step();
            id = (cyc / 4) % 4;
            check($sformatf("scan0_sel_c%0d", cyc), digit_sel, (id == 0) ? 4'b1110 : 4'b1111);
            check($sformatf("scan0_blank_c%0d", cyc), blank, (id == 0) ? 1'b0 : 1'b1);
        end

        // Scan values of 0x0507: the load edge (cyc 17) precedes a full fresh rotation
        load = 1'b1; load_val = 16'h0507;
        step();
        load = 1'b0;
        n = 0;
        while (cyc < 32 && n < 40) begin
            step();
            n++;
        end
        for (int k = 0; k < 16; k++) begin
            id = (cyc / 4) % 4;
            case (id)
                0:       begin bexp = 4'd7; sexp = 4'b1110; end
                1:       begin bexp = 4'd0; sexp = 4'b1101; end
                2:       begin bexp = 4'd5; sexp = 4'b1011; end
                default: begin bexp = 4'd0; sexp = 4'b1111; end
            endcase
            check($sformatf("scan1_bcd_c%0d", cyc), bcd_out, bexp);
            check($sformatf("scan1_sel_c%0d", cyc), digit_sel, sexp);
            check($sformatf("scan1_blank_c%0d", cyc), blank, (id == 3) ? 1'b1 : 1'b0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
